// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage RISC-V core.
// Detects load-use hazards (decode bubble + front-end stall), sequences
// taken-branch flushes over BR_PENALTY cycles, and freezes the front end
// while data memory is busy. Two saturating perf counters are exported.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   if_id_rs1/rs2/opcode       fields of the instruction in IF/ID
//   id_ex_MemRead, id_ex_Rd    load flag and destination of ID/EX
//   ex_branch_taken            branch in EX resolved taken this cycle
//   mem_busy                   data memory stall request
//   pc_write, if_id_write      front-end load enables (combinational)
//   hazard_detected            bubble request to decode (combinational)
//   if_id_flush, id_ex_flush   pipeline register clears (combinational)
//   stall_cycles               cycles with pc_write=0, saturating
//   flush_events               accepted taken branches, saturating
module hazard_ctrl #(
  parameter int unsigned BR_PENALTY = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic [6:0]       if_id_opcode,
  input  logic             id_ex_MemRead,
  input  logic [4:0]       id_ex_Rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             hazard_detected,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] FLUSH_INIT = 3'(BR_PENALTY - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t     state, state_nxt, eff_state;
  logic [2:0] flush_cnt, flush_cnt_nxt;
  logic       ret_flush, ret_flush_nxt;
  logic       uses_rs2, load_use, branch_accept;

  // Hazard detection against the load in ID/EX
  assign uses_rs2 = (if_id_opcode == OP_RTYPE) || (if_id_opcode == OP_STORE) ||
                    (if_id_opcode == OP_BRANCH);
  assign load_use = id_ex_MemRead && (id_ex_Rd != 5'd0) &&
                    ((id_ex_Rd == if_id_rs1) || (uses_rs2 && (id_ex_Rd == if_id_rs2)));

  // MEM_WAIT releasing this cycle behaves as the state it returns to
  always_comb begin
    eff_state = state;
    if (state == ST_MEM_WAIT && !mem_busy) begin
      eff_state = ret_flush ? ST_FLUSH : ST_RUN;
    end
  end

  // Next-state and control outputs
  always_comb begin
    state_nxt       = state;
    flush_cnt_nxt   = flush_cnt;
    ret_flush_nxt   = ret_flush;
    branch_accept   = 1'b0;
    pc_write        = 1'b0;
    if_id_write     = 1'b0;
    hazard_detected = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;

    if (!rst_n) begin
      state_nxt = ST_RUN;
    end else if (mem_busy) begin
      state_nxt = ST_MEM_WAIT;
      if (state != ST_MEM_WAIT) begin
        ret_flush_nxt = (state == ST_FLUSH);
      end
    end else begin
      case (eff_state)
        ST_RUN: begin
          state_nxt = ST_RUN;
          if (ex_branch_taken) begin
            pc_write      = 1'b1;
            if_id_write   = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            branch_accept = 1'b1;
            if (BR_PENALTY > 1) begin
              state_nxt     = ST_FLUSH;
              flush_cnt_nxt = FLUSH_INIT;
            end
          end else if (load_use) begin
            hazard_detected = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
        ST_FLUSH: begin
          pc_write      = 1'b1;
          if_id_write   = 1'b1;
          if_id_flush   = 1'b1;
          flush_cnt_nxt = flush_cnt - 3'd1;
          state_nxt     = (flush_cnt == 3'd1) ? ST_RUN : ST_FLUSH;
        end
        default: begin
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // State, flush bookkeeping and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      flush_cnt    <= 3'd0;
      ret_flush    <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      ret_flush <= ret_flush_nxt;
      if (!pc_write && !(&stall_cycles)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (branch_accept && !(&flush_events)) begin
        flush_events <= flush_events + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core. It sits beside the decode stage and does three jobs. It detects load-use hazards and drives the decode-stage `hazard_detected` bubble input. It sequences branch-taken flushes over a configurable penalty window. It freezes the whole front end while data memory reports busy. Two saturating performance counters (stall cycles, flush events) are exposed for debug and for the testbench.

## Interface

**Parameters**
- `BR_PENALTY`, default 2: number of cycles IF/ID is flushed after a taken branch. Legal range is 1..7.
- `CNT_W`, default 16: width of the performance counters.

**Ports**
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_id_rs1`  in  5  rs1 field of the instruction in IF/ID.
- `if_id_rs2`  in  5  rs2 field of the instruction in IF/ID.
- `if_id_opcode`  in  7  opcode of the instruction in IF/ID.
- `id_ex_MemRead`  in  1  instruction in ID/EX is a load.
- `id_ex_Rd`  in  5  destination register of the instruction in ID/EX.
- `ex_branch_taken`  in  1  the branch in EX resolved taken this cycle.
- `mem_busy`  in  1  data memory cannot accept or complete an access this cycle.
- `pc_write`  out  1  PC register load enable.
- `if_id_write`  out  1  IF/ID register load enable.
- `hazard_detected`  out  1  to decode; zeroes the ID/EX control fields (bubble).
- `if_id_flush`  out  1  clear IF/ID to NOP at the next edge.
- `id_ex_flush`  out  1  clear ID/EX to NOP at the next edge.
- `stall_cycles`  out  CNT_W  count of cycles with `pc_write`=0 while out of reset; saturating.
- `flush_events`  out  CNT_W  count of accepted taken branches; saturating.

## Operation

**Definitions**
- `uses_rs2` = `if_id_opcode` ∈ {0110011 (R-type), 0100011 (store), 1100011 (branch)}.
- `load_use` = `id_ex_MemRead` & (`id_ex_Rd`≠0) & (`id_ex_Rd`==`if_id_rs1` | (`uses_rs2` & `id_ex_Rd`==`if_id_rs2`)).

**States**
- RUN (reset state), FLUSH, MEM_WAIT.
- A 3-bit `flush_cnt` register and a 1-bit `ret_flush` register are held alongside the state.

**Outputs.** All outputs are combinational from the state and the inputs. They are evaluated in this priority order; the first matching rule applies:
1. `rst_n`=0: `pc_write`=0 and `if_id_write`=0; all other control outputs 0.
2. `mem_busy`=1, in any state: `pc_write`=0, `if_id_write`=0, `hazard_detected`=0, both flushes 0. The pipeline holds; no bubble is inserted.
3. RUN with `ex_branch_taken`=1: `pc_write`=1 (redirect), `if_id_write`=1, `if_id_flush`=1, `id_ex_flush`=1, `hazard_detected`=0. `load_use` is ignored.
4. RUN with `load_use`=1: `pc_write`=0, `if_id_write`=0, `hazard_detected`=1, flushes 0.
5. RUN otherwise: `pc_write`=1, `if_id_write`=1, all others 0.
6. FLUSH: `pc_write`=1, `if_id_write`=1, `if_id_flush`=1, `id_ex_flush`=0, `hazard_detected`=0. `load_use` is ignored.

**Transitions** (evaluated at the rising edge, `rst_n`=1)
- Any state with `mem_busy`=1 → MEM_WAIT.
  - `ret_flush` is loaded with 1 if the current state is FLUSH, otherwise 0.
  - `flush_cnt` is held.
  - If already in MEM_WAIT, `ret_flush` is held.
- MEM_WAIT with `mem_busy`=0 → FLUSH if `ret_flush`=1, else RUN. Outputs in that cycle follow the target state's rules; the state register still reads MEM_WAIT but is decoded as the return state.
- RUN with `ex_branch_taken`=1:
  - If `BR_PENALTY`>1 → FLUSH with `flush_cnt`=`BR_PENALTY`−1.
  - Otherwise stay in RUN.
  - `flush_events` increments.
- FLUSH: `flush_cnt` decrements. When `flush_cnt`==1 at the edge → RUN.
- FLUSH with `ex_branch_taken`=1 (illegal, since ID/EX is flushed): ignored, no count.

**Counters**
- `stall_cycles` increments on every edge where `rst_n`=1 and `pc_write`=0.
- Both counters saturate at 2^CNT_W−1 and never wrap.
- An asynchronous reset clears both counters to 0.

**Reset**
- Asserting `rst_n` forces RUN, `flush_cnt`=0, `ret_flush`=0 and counters 0 immediately, including mid-FLUSH or mid-MEM_WAIT.

## Timing

- Load-use, branch and `mem_busy` responses are same-cycle combinational; there is no added latency.
- The state effect takes hold from the next edge.
- Load-use stall lasts exactly one cycle. The next cycle ID/EX holds the bubble, so `id_ex_MemRead`=0.
- Taken branch: the branch cycle plus `BR_PENALTY`−1 FLUSH cycles of `if_id_flush`=1.
- MEM_WAIT adds exactly as many cycles as `mem_busy` stays high. A FLUSH interrupted by MEM_WAIT resumes with its remaining count.
- Reset value of the outputs while `rst_n`=0: `pc_write`=0, `if_id_write`=0, `hazard_detected`=0, `if_id_flush`=0, `id_ex_flush`=0, `stall_cycles`=0, `flush_events`=0.

## Test plan

- **Load-use on rs1:** `id_ex_MemRead`=1, `id_ex_Rd`=5, `if_id_rs1`=5, opcode 0010011 → one cycle of `hazard_detected`=1, `pc_write`=0; `stall_cycles`=1.
- **rs2 gating:** `id_ex_Rd`=6, `if_id_rs2`=6, opcode 0010011 → no stall. Same with opcode 0110011 → stall. `id_ex_Rd`=0 matching `if_id_rs1`=0 → no stall.
- **Taken branch with `BR_PENALTY`=2:** pulse `ex_branch_taken` → `if_id_flush`=1 for 2 cycles, `id_ex_flush`=1 only in the first, `pc_write`=1 throughout; `flush_events`=1. Simultaneous `load_use` is ignored.
- **`mem_busy` during FLUSH (`BR_PENALTY`=3):** `mem_busy` high for 3 cycles after the first FLUSH cycle → 3 frozen cycles, then exactly 1 more `if_id_flush` cycle, then RUN; `stall_cycles`=3.
- **Priority:** `mem_busy`=1 together with `ex_branch_taken`=1 and `load_use`=1 → full freeze, no flush, no count; the branch is re-accepted once `mem_busy`=0.
- **Reset mid-FLUSH, and saturation:** drop `rst_n` mid-FLUSH → all outputs at reset values immediately. With `CNT_W`=4, 20 stall cycles → `stall_cycles`=15.
